// File: rtl/circle_seq.sv
// circle_seq: optional full-frame clear (CIRCLE_SEQ_CLEAR_EN) followed by a circle-engine
// run with latched parameters; clear and circle pixels share the single VGA plot port.
module circle_seq #(
   parameter int         SCREEN_W     = 160,
   parameter int         SCREEN_H     = 120,
   parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] colour,
   input  logic [7:0] centre_x,
   input  logic [6:0] centre_y,
   input  logic [7:0] radius,
   output logic       done,
   output logic       circ_start,
   output logic [2:0] circ_colour,
   output logic [7:0] circ_centre_x,
   output logic [6:0] circ_centre_y,
   output logic [7:0] circ_radius,
   input  logic       circ_done,
   input  logic [7:0] circ_x,
   input  logic [6:0] circ_y,
   input  logic [2:0] circ_colour_in,
   input  logic       circ_plot,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_DRAW  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [7:0] X_LIM = 8'(SCREEN_W);
   localparam logic [6:0] Y_LIM = 7'(SCREEN_H);

   state_t     state_q;
   logic       done_q;
   logic       circ_start_q;
   logic [2:0] colour_q;
   logic [7:0] centre_x_q;
   logic [6:0] centre_y_q;
   logic [7:0] radius_q;
`ifdef CIRCLE_SEQ_CLEAR_EN
   localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
   localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);
   logic [7:0] cx_q;
   logic [6:0] cy_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         done_q       <= 1'b0;
         circ_start_q <= 1'b0;
         colour_q     <= '0;
         centre_x_q   <= '0;
         centre_y_q   <= '0;
         radius_q     <= '0;
`ifdef CIRCLE_SEQ_CLEAR_EN
         cx_q         <= '0;
         cy_q         <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  colour_q   <= colour;
                  centre_x_q <= centre_x;
                  centre_y_q <= centre_y;
                  radius_q   <= radius;
`ifdef CIRCLE_SEQ_CLEAR_EN
                  cx_q       <= '0;
                  cy_q       <= '0;
                  state_q    <= S_CLEAR;
`else
                  state_q      <= S_DRAW;
                  circ_start_q <= 1'b1;
`endif
               end
            end
`ifdef CIRCLE_SEQ_CLEAR_EN
            // y runs fastest; the last column's last row hands over to the engine
            S_CLEAR: begin
               if (cy_q == Y_LAST) begin
                  cy_q <= '0;
                  if (cx_q == X_LAST) begin
                     cx_q         <= '0;
                     state_q      <= S_DRAW;
                     circ_start_q <= 1'b1;
                  end else begin
                     cx_q <= cx_q + 8'd1;
                  end
               end else begin
                  cy_q <= cy_q + 7'd1;
               end
            end
`endif
            S_DRAW: begin
               if (circ_done) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               if (!start) begin
                  state_q      <= S_IDLE;
                  done_q       <= 1'b0;
                  circ_start_q <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Engine pixels pass straight through; off-screen ones lose their strobe only
   always_comb begin
      vga_x      = '0;
      vga_y      = '0;
      vga_colour = '0;
      vga_plot   = 1'b0;
      case (state_q)
`ifdef CIRCLE_SEQ_CLEAR_EN
         S_CLEAR: begin
            vga_x      = cx_q;
            vga_y      = cy_q;
            vga_colour = CLEAR_COLOUR;
            vga_plot   = 1'b1;
         end
`endif
         S_DRAW: begin
            vga_x      = circ_x;
            vga_y      = circ_y;
            vga_colour = circ_colour_in;
            vga_plot   = circ_plot & (circ_x < X_LIM) & (circ_y < Y_LIM);
         end
         default: ;
      endcase
   end

   assign done          = done_q;
   assign circ_start    = circ_start_q;
   assign circ_colour   = colour_q;
   assign circ_centre_x = centre_x_q;
   assign circ_centre_y = centre_y_q;
   assign circ_radius   = radius_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_circle_seq.sv
// tb_circle_seq: random circle runs against a pixel-list reference model of circle_seq;
// expectations follow CIRCLE_SEQ_CLEAR_EN the same way the design does.
module tb_circle_seq;

   localparam int W = 160;
   localparam int H = 120;
`ifdef CIRCLE_SEQ_CLEAR_EN
   localparam int CLEAR_PIX = W * H;
`else
   localparam int CLEAR_PIX = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] colour = '0;
   logic [7:0] centre_x = '0;
   logic [6:0] centre_y = '0;
   logic [7:0] radius = '0;
   logic       done, circ_start;
   logic [2:0] circ_colour;
   logic [7:0] circ_centre_x;
   logic [6:0] circ_centre_y;
   logic [7:0] circ_radius;
   logic       circ_done = 1'b0;
   logic [7:0] circ_x = '0;
   logic [6:0] circ_y = '0;
   logic [2:0] circ_colour_in = '0;
   logic       circ_plot = 1'b0;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic [1:0] dbg_state;

   int tests = 0;
   int fails = 0;
   logic [17:0] exp_q[$];

   circle_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .colour(colour),
      .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
      .done(done), .circ_start(circ_start), .circ_colour(circ_colour),
      .circ_centre_x(circ_centre_x), .circ_centre_y(circ_centre_y),
      .circ_radius(circ_radius), .circ_done(circ_done), .circ_x(circ_x),
      .circ_y(circ_y), .circ_colour_in(circ_colour_in), .circ_plot(circ_plot),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Every plotted pixel must be the next one the model predicted
   always @(negedge clk) begin
      if (rst_n && vga_plot) begin
         if (exp_q.size() == 0) check("unexpected_plot", {14'd0, vga_x, vga_y, vga_colour}, 32'h3ffff);
         else check("pixel", {14'd0, vga_x, vga_y, vga_colour}, {14'd0, exp_q.pop_front()});
      end
   end

   task automatic check_all_zero(input string pfx);
      check({pfx, "_done"}, done, 0);
      check({pfx, "_circ_start"}, circ_start, 0);
      check({pfx, "_vga_plot"}, vga_plot, 0);
      check({pfx, "_vga_xyc"}, {vga_x, vga_y, vga_colour}, 0);
      check({pfx, "_circ_params"}, {circ_colour, circ_centre_x, circ_centre_y, circ_radius}, 0);
   endtask

   task automatic push_clear();
      for (int x = 0; x < CLEAR_PIX / H; x++)
         for (int y = 0; y < H; y++)
            exp_q.push_back({8'(x), 7'(y), 3'b000});
   endtask

   task automatic wait_circ_start(output int n);
      n = 0;
      while (!circ_start && n < CLEAR_PIX + 100) begin
         @(posedge clk); #1;
         n++;
         if (n == 3) begin
            colour = 3'($urandom); centre_x = 8'($urandom);
            centre_y = 7'($urandom); radius = 8'($urandom);
         end
      end
   endtask

   task automatic drive_pix(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
      @(posedge clk); #1;
      circ_x = x; circ_y = y; circ_colour_in = c; circ_plot = 1'b1;
      if (x < W && y < H) exp_q.push_back({x, y, c});
      @(posedge clk); #1;
      circ_plot = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
   endtask

   task automatic do_run(input int idx, input bit early_done);
      logic [2:0] c;
      logic [7:0] px, r;
      logic [6:0] py;
      int n;
      c = 3'($urandom); px = 8'($urandom); py = 7'($urandom); r = 8'($urandom);
      if (idx == 0) begin c = 3'b010; px = 8'd80; py = 7'd60; r = 8'd40; end
      colour = c; centre_x = px; centre_y = py; radius = r;
      push_clear();
      circ_done = early_done;
      @(posedge clk); #1;
      start = 1'b1;
      wait_circ_start(n);
      check("circ_start_latency", n, 1 + CLEAR_PIX);
      check("clear_pixels_left", exp_q.size(), 0);
      check("latched_params", {circ_colour, circ_centre_x, circ_centre_y, circ_radius},
            {c, px, py, r});
      colour = 3'($urandom); centre_x = 8'($urandom); radius = 8'($urandom);
      if (early_done) begin
         @(posedge clk); #1;
         circ_done = 1'b0;
         check("early_done", done, 1);
      end else begin
         if (idx == 0) begin
            drive_pix(8'd200, 7'd10, 3'd5);
            drive_pix(8'd10, 7'd125, 3'd6);
            drive_pix(8'd159, 7'd119, 3'd7);
         end
         if (idx == 1) start = 1'b0;
         for (int i = 0; i < 16; i++)
            drive_pix(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)), 3'($urandom));
         start = 1'b1;
         check("draw_not_done", done, 0);
         @(posedge clk); #1;
         circ_done = 1'b1;
         @(posedge clk); #1;
         circ_done = 1'b0;
         check("done_after_pulse", done, 1);
      end
      check("draw_pixels_left", exp_q.size(), 0);
      circ_x = 8'd5; circ_y = 7'd5; circ_plot = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("done_hold", done, 1);
         check("circ_start_hold", circ_start, 1);
      end
      circ_plot = 1'b0;
      check("params_stable", {circ_colour, circ_centre_x, circ_centre_y, circ_radius},
            {c, px, py, r});
      start = 1'b0;
      @(posedge clk); #1;
      check("done_drop", done, 0);
      check("circ_start_drop", circ_start, 0);
      check("idle_vga", {vga_plot, vga_x, vga_y, vga_colour}, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      circ_x = 8'd3; circ_y = 7'd4; circ_colour_in = 3'd1; circ_plot = 1'b1;
      repeat (5) @(posedge clk);
      #1 check("idle_no_start", circ_start, 0);
      circ_plot = 1'b0;

      // abort a run with reset, then make sure nothing plots until a new start
      push_clear();
      centre_x = 8'd9; radius = 8'd7;
      @(posedge clk); #1 start = 1'b1;
      repeat (50) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_all_zero("midrun_reset");
      exp_q.delete();
      start = 1'b0;
      @(posedge clk); #2 rst_n = 1'b1;
      circ_x = 8'd1; circ_y = 7'd1; circ_plot = 1'b1;
      repeat (5) @(posedge clk);
      #1 check("post_reset_idle", circ_start, 0);
      circ_plot = 1'b0;

      do_run(0, 1'b0);
      do_run(1, 1'b0);
      do_run(2, 1'b1);
      repeat (2) @(posedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
